ysyx_22041461_wb_queue: RTL
===========================

// Module: ysyx_22041461_wb_queue
// PURPOSE
//  Write-back queue feeding the GPR file write port. Buffers {rd,data} results from EXU/LSU/CSR
//  paths via valid/ready, issues them in order, one per cycle, through a registered write port.
//  Forwards the youngest pending value of rs1/rs2 to decode so reads never see stale GPRs.
// PARAMETERS
//  DEPTH  4   queue entries, power of 2, >=2 (total capacity DEPTH+1 incl. output register)
//  XLEN   64  data width
// PORTS
//  clk           in   1      clock, all state on posedge
//  rst           in   1      asynchronous, active-low reset
//  in_valid      in   1      producer offers a result
//  in_ready      out  1      queue accepts; handshake = in_valid & in_ready
//  in_rd         in   5      destination register
//  in_data       in   XLEN   result value
//  wr_en         out  1      write pending on register-file port (registered)
//  wr_rd         out  5      write index (registered)
//  wr_data       out  XLEN   write value (registered)
//  wr_ready      in   1      register file commits wr_* at this edge when wr_en & wr_ready
//  rs1, rs2      in   5      decode read indices
//  rs1_hit       out  1      rs1 pending in queue or output register
//  rs1_fwd       out  XLEN   youngest pending value for rs1, 0 when no hit
//  rs2_hit       out  1      as rs1
//  rs2_fwd       out  XLEN   as rs1
//  count         out  clog2(DEPTH)+1  queue occupancy 0..DEPTH (excludes output register)
// BEHAVIOUR
//  Reset (rst=0, async): head=tail=0, count=0, wr_en=0, wr_rd=0, wr_data=0; queue contents
//   discarded, no write issued; in_ready=1, hits=0, fwd=0 immediately. Reset mid-stream drops all.
//  Storage: circular buffer, head/tail wrap modulo DEPTH; count tracks occupancy.
//  in_ready = (count != DEPTH). Purely from registered state, no comb path from wr_ready.
//  Accept with in_rd==0: handshake completes, nothing stored, count unchanged (x0 is never written).
//  Accept with in_rd!=0: entry written at tail, tail+1, count+1.
//  Output stage loads when (!wr_en | wr_ready):
//   - queue non-empty -> wr_* <= head entry, wr_en<=1, head+1, count-1
//   - queue empty     -> wr_en<=0, wr_rd/wr_data hold
//   otherwise (wr_en & !wr_ready) wr_* hold unchanged, queue not popped.
//  Push and pop in same edge: both take effect, count unchanged. When count==DEPTH no push, even
//   if popping that edge.
//  Empty queue bypass: none; accepted at edge N -> on wr_* after edge N+1 -> committed at edge
//   N+2 if wr_ready.
//  Strict FIFO order: writes leave in acceptance order, no coalescing of equal rd.
//  Forwarding (combinational from state): candidates are wr_* (if wr_en) and all valid queue
//   entries; rsX==0 -> hit=0, fwd=0. Priority youngest first: entry at tail-1 ... head, then wr_*.
//   in_* in the current cycle are not candidates.
//  Producer holding in_valid while in_ready=0: no state change; producer keeps data stable.
// TESTING
//  1 reset, wr_ready=1, push rd=5 data=0x1234 at edge 1 -> wr_en=1,wr_rd=5,wr_data=0x1234 after
//    edge 2 for one cycle, wr_en=0 after edge 3, count=0 throughout after edge 2.
//  2 wr_ready=0, offer rd=1..6 back-to-back -> rd1 in wr_*, rd2..5 queued, count=4, in_ready=0
//    with rd6 held; wr_ready=1 -> wr_rd 1,2,3,4,5,6 on consecutive cycles, no gaps/reordering.
//  3 wr_ready=0, queue rd=7 data=0xA then rd=7 data=0xB; rs1=7,rs2=0 -> rs1_hit=1 rs1_fwd=0xB,
//    rs2_hit=0 rs2_fwd=0; after both retire rs1_hit=0.
//  4 push rd=0 data=0xFFFF -> handshake completes, count stays 0, wr_en never rises.
//  5 count=2, wr_ready=1, push each edge for 8 cycles -> count stays 2, pointers wrap, output
//    order equals input order.
//  6 count=3, wr_en=1, drop rst mid-cycle -> wr_en=0,count=0,in_ready=1,hits=0 before next edge;
//    after release first push behaves as test 1.

Source files
------------

// File: rtl/ysyx_22041461_wb_queue.sv
// ---------------------------------------------------------------------------
// ysyx_22041461_wb_queue
//
// Write-back queue in front of the GPR file write port. Results from the
// EXU/LSU/CSR paths are accepted over valid/ready and stored in a small
// circular buffer. They are then issued strictly in acceptance order, one per
// cycle, through a registered write port (wr_*). Decode can look up rs1/rs2
// against everything still pending, so it never reads a stale GPR. The
// youngest pending value for an index wins.
//
// Ports
//   clk_i        clock, all state updates on the rising edge
//   rst_ni       asynchronous active-low reset
//   in_valid_i   producer offers {in_rd_i, in_data_i}
//   in_ready_o   queue can accept (depends on registered occupancy only)
//   in_rd_i      destination register (x0 results are accepted and dropped)
//   in_data_i    result value
//   wr_en_o      write pending on the register-file port
//   wr_rd_o      write index
//   wr_data_o    write value
//   wr_ready_i   register file commits wr_* at this edge when wr_en_o is set
//   rs1_i/rs2_i  decode read indices
//   rsX_hit_o    index is pending in the queue or in the write register
//   rsX_fwd_o    youngest pending value for the index, 0 when no hit
//   count_o      queue occupancy 0..DEPTH (write register not included)
// ---------------------------------------------------------------------------
module ysyx_22041461_wb_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 64
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [4:0]               in_rd_i,
    input  logic [XLEN-1:0]          in_data_i,
    output logic                     wr_en_o,
    output logic [4:0]               wr_rd_o,
    output logic [XLEN-1:0]          wr_data_o,
    input  logic                     wr_ready_i,
    input  logic [4:0]               rs1_i,
    input  logic [4:0]               rs2_i,
    output logic                     rs1_hit_o,
    output logic [XLEN-1:0]          rs1_fwd_o,
    output logic                     rs2_hit_o,
    output logic [XLEN-1:0]          rs2_fwd_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [4:0]      mem_rd_q   [DEPTH];
    logic [XLEN-1:0] mem_data_q [DEPTH];

    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic            wr_en_q, wr_en_d;
    logic [4:0]      wr_rd_q, wr_rd_d;
    logic [XLEN-1:0] wr_data_q, wr_data_d;

    logic push, load, pop;

    assign in_ready_o = (count_q != CW'(DEPTH));

    // x0 results complete the handshake but never occupy an entry.
    assign push = in_valid_i & in_ready_o & (in_rd_i != 5'd0);
    assign load = ~wr_en_q | wr_ready_i;
    assign pop  = load & (count_q != '0);

    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        wr_en_d   = wr_en_q;
        wr_rd_d   = wr_rd_q;
        wr_data_d = wr_data_q;

        if (pop)  head_d = head_q + PW'(1);
        if (push) tail_d = tail_q + PW'(1);

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // On an empty queue the write register only drops wr_en; index and
        // data are left as they were.
        if (load) begin
            if (count_q != '0) begin
                wr_en_d   = 1'b1;
                wr_rd_d   = mem_rd_q[head_q];
                wr_data_d = mem_data_q[head_q];
            end else begin
                wr_en_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_rd_q   <= '0;
            wr_data_q <= '0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            wr_en_q   <= wr_en_d;
            wr_rd_q   <= wr_rd_d;
            wr_data_q <= wr_data_d;
        end
    end

    // Entry storage has no reset. Only entries inside [head, head+count) are
    // ever read, and count clears on reset.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_rd_q[tail_q]   <= in_rd_i;
            mem_data_q[tail_q] <= in_data_i;
        end
    end

    // The search runs oldest to youngest so that later matches overwrite
    // earlier ones. The write register is older than every queued entry.
    function automatic logic [XLEN:0] lookup(input logic [4:0] rs);
        logic [XLEN:0] res;
        logic [PW-1:0] idx;
        res = '0;
        idx = '0;
        if (rs != 5'd0) begin
            if (wr_en_q && (wr_rd_q == rs)) res = {1'b1, wr_data_q};
            for (int i = 0; i < DEPTH; i++) begin
                idx = head_q + PW'(i);
                if ((CW'(i) < count_q) && (mem_rd_q[idx] == rs))
                    res = {1'b1, mem_data_q[idx]};
            end
        end
        return res;
    endfunction

    always_comb begin
        {rs1_hit_o, rs1_fwd_o} = lookup(rs1_i);
        {rs2_hit_o, rs2_fwd_o} = lookup(rs2_i);
    end

    assign wr_en_o   = wr_en_q;
    assign wr_rd_o   = wr_rd_q;
    assign wr_data_o = wr_data_q;
    assign count_o   = count_q;

endmodule
